// File: rtl/alu_exec_if.sv
// alu_exec_if: request/response bundle for the integer execute unit.
//   Request : in_valid, in_ready, alu_control, operand_a, operand_b, shamt
//   Response: out_valid, out_ready, result, zero, overflow, illegal
//   master = requester/consumer side, slave = execute unit side.
interface alu_exec_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, alu_control, operand_a, operand_b, shamt, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal
  );

  modport slave (
    input  in_valid, alu_control, operand_a, operand_b, shamt, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: integer execute unit driven by the 4-bit ALU control code.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_exec_if.slave (request handshake in, registered result/flags out)
// Logic/arith ops resolve in the accept cycle; SLL/SRL walk one bit per cycle
// so no barrel shifter is built. FP codes (11xx) and unused codes raise illegal.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_exec_if.slave    bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1011;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic             in_ready_q, out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, ovf_q, ill_q;
  logic [WIDTH-1:0] sh_reg;
  logic [SHW-1:0]   cnt;
  logic             sh_left;

  // single-cycle datapath, evaluated on the live request inputs
  logic [WIDTH-1:0] a, b, sum, diff, alu_res, sh_next;
  logic             alu_ovf, alu_ill, is_shift;

  assign a        = bus.operand_a;
  assign b        = bus.operand_b;
  assign sum      = a + b;
  assign diff     = a - b;
  assign is_shift = (bus.alu_control == OP_SLL) || (bus.alu_control == OP_SRL);
  assign sh_next  = sh_left ? (sh_reg << 1) : (sh_reg >> 1);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (bus.alu_control)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      // only reached with shamt==0; nonzero amounts take the SHIFT path
      OP_SLL, OP_SRL: alu_res = b;
      OP_XOR: alu_res = a ^ b;
      OP_NOR: alu_res = ~(a | b);
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
      sh_reg      <= '0;
      cnt         <= '0;
      sh_left     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          in_ready_q <= 1'b0;
          if (is_shift && (bus.shamt != '0)) begin
            sh_reg  <= b;
            cnt     <= bus.shamt;
            sh_left <= (bus.alu_control == OP_SLL);
            state   <= SHIFT;
          end else begin
            result_q    <= alu_res;
            zero_q      <= (alu_res == '0);
            ovf_q       <= alu_ovf;
            ill_q       <= alu_ill;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        SHIFT: begin
          sh_reg <= sh_next;
          cnt    <= cnt - SHW'(1);
          // last bit moves on the edge that also publishes the result,
          // giving shamt+1 edges from acceptance to out_valid
          if (cnt == SHW'(1)) begin
            result_q    <= sh_next;
            zero_q      <= (sh_next == '0);
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.illegal   = ill_q;
endmodule
